// File: rtl/serial_pkg.sv
// Shared types and constants for the serial deserializer block.
// Holds the frame FSM state encoding and the default frame width.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/bit_count.sv
// Data-bit counter for the deserializer: cleared by Init, advanced by Inc,
// saturating at WIDTH. Co flags the count at which the final data bit is taken.
module bit_count
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Init,
    input  logic                         Inc,
    output logic [$clog2(WIDTH+1)-1:0]   Cnt,
    output logic                         Co
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Init) begin
            cnt_d = '0;
        end else if (Inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Cnt = cnt_q;
    assign Co  = (cnt_q == CNT_LAST);

endmodule

// File: rtl/serial_deserializer.sv
// Start-bit framed serial receiver with optional even parity and a one-word
// output buffer (Valid/Ack handshake, sticky Overrun on dropped frames).
module serial_deserializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 0,
    parameter int PARITY_EN = 0
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         SerI,
    input  logic                         En,
    input  logic                         Ack,
    output logic [WIDTH-1:0]             Dout,
    output logic                         Valid,
    output logic                         Busy,
    output logic                         ParErr,
    output logic                         Overrun,
    output logic [$clog2(WIDTH+1)-1:0]   BitCnt
);

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic             par_bit_q;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             parerr_q;
    logic             overrun_q;
    logic             commit_q;
    logic             parerr_d;
    logic             cnt_init;
    logic             cnt_inc;
    logic             cnt_co;

    assign cnt_init = (state_q == IDLE) && En && !SerI;
    assign cnt_inc  = (state_q == SHIFT) && En;

    bit_count #(
        .WIDTH (WIDTH)
    ) u_bit_count (
        .Clk  (Clk),
        .Rst  (Rst),
        .Init (cnt_init),
        .Inc  (cnt_inc),
        .Cnt  (BitCnt),
        .Co   (cnt_co)
    );

    // Per-bit shift network: the first received bit walks toward bit 0 (LSB
    // first) or toward bit WIDTH-1 (MSB first) as later bits arrive.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (MSB_FIRST != 0) begin : g_msb
            if (gi == 0) begin : g_in
                assign shift_d[gi] = SerI;
            end else begin : g_mv
                assign shift_d[gi] = shift_q[gi-1];
            end
        end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_in
                assign shift_d[gi] = SerI;
            end else begin : g_mv
                assign shift_d[gi] = shift_q[gi+1];
            end
        end
    end

    assign parerr_d = (PARITY_EN != 0) ? ((^shift_q) ^ par_bit_q) : 1'b0;

    // DONE only decides accept/drop; the accepted word lands in the buffer one
    // edge later via commit_q, while the next frame's start bit is already seen.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            parerr_q  <= 1'b0;
            overrun_q <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (En && !SerI) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (En) begin
                        shift_q <= shift_d;
                        if (cnt_co) begin
                            state_q <= (PARITY_EN != 0) ? PARITY : DONE;
                        end
                    end
                end
                PARITY: begin
                    if (En) begin
                        par_bit_q <= SerI;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (!valid_q || Ack) begin
                        commit_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (commit_q) begin
                dout_q   <= shift_q;
                parerr_q <= parerr_d;
                valid_q  <= 1'b1;
            end else if (Ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign Dout    = dout_q;
    assign Valid   = valid_q;
    assign Busy    = (state_q != IDLE);
    assign ParErr  = parerr_q;
    assign Overrun = overrun_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: LSB-first, MSB-first and parity
// instances share clock, reset, data line and Ack; En is steered per test.
module tb_serial_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n    = 1'b0;
    logic ser      = 1'b1;
    logic en       = 1'b0;
    logic ack      = 1'b0;
    logic par_mode = 1'b0;
    logic en_a;
    logic en_p;

    assign en_a = en & ~par_mode;
    assign en_p = en & par_mode;

    logic [7:0] dout_a, dout_b, dout_p;
    logic       valid_a, valid_b, valid_p;
    logic       busy_a, busy_b, busy_p;
    logic       parerr_a, parerr_b, parerr_p;
    logic       ovr_a, ovr_b, ovr_p;
    logic [3:0] cnt_a, cnt_b, cnt_p;

    int checks = 0;
    int passes = 0;

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) u_lsb (
        .Clk(clk), .Rst(rst_n), .SerI(ser), .En(en_a), .Ack(ack),
        .Dout(dout_a), .Valid(valid_a), .Busy(busy_a), .ParErr(parerr_a),
        .Overrun(ovr_a), .BitCnt(cnt_a)
    );

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) u_msb (
        .Clk(clk), .Rst(rst_n), .SerI(ser), .En(en_a), .Ack(ack),
        .Dout(dout_b), .Valid(valid_b), .Busy(busy_b), .ParErr(parerr_b),
        .Overrun(ovr_b), .BitCnt(cnt_b)
    );

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1)) u_par (
        .Clk(clk), .Rst(rst_n), .SerI(ser), .En(en_p), .Ack(ack),
        .Dout(dout_p), .Valid(valid_p), .Busy(busy_p), .ParErr(parerr_p),
        .Overrun(ovr_p), .BitCnt(cnt_p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start bit, data LSB first, optional parity bit. Returns just after the
    // edge that samples the final bit. With gaps, an En=0 cycle carrying the
    // inverted bit follows every bit but the last.
    task automatic send_frame(input logic [7:0] data, input bit with_par,
                              input logic pbit, input bit gaps);
        logic [9:0] seq;
        int n;
        seq = {pbit, data, 1'b0};
        n   = with_par ? 10 : 9;
        for (int i = 0; i < n; i++) begin
            ser = seq[i];
            en  = 1'b1;
            tick();
            if (gaps && i < n - 1) begin
                en  = 1'b0;
                ser = ~seq[i];
                tick();
            end
        end
        ser = 1'b1;
        en  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ser = 1'b1; en = 1'b0; ack = 1'b0; par_mode = 1'b0;
        tick();
        tick();
        checks++; if (dout_a !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout_a); else passes++;
        checks++; if (valid_a !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_a); else passes++;
        checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_a); else passes++;
        checks++; if (parerr_a !== 1'b0) $display("FAIL reset_parerr: got %b expected 0", parerr_a); else passes++;
        checks++; if (ovr_a !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", ovr_a); else passes++;
        checks++; if (cnt_a !== 4'd0) $display("FAIL reset_bitcnt: got %0d expected 0", cnt_a); else passes++;
        checks++; if (dout_b !== 8'h00) $display("FAIL reset_dout_msb: got %h expected 00", dout_b); else passes++;
        checks++; if (valid_p !== 1'b0) $display("FAIL reset_valid_par: got %b expected 0", valid_p); else passes++;
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_bit_order();
        par_mode = 1'b0;
        send_frame(8'hB7, 1'b0, 1'b0, 1'b0);
        checks++; if (busy_a !== 1'b1) $display("FAIL order_busy_done: got %b expected 1", busy_a); else passes++;
        checks++; if (valid_a !== 1'b0) $display("FAIL order_valid_e0: got %b expected 0", valid_a); else passes++;
        checks++; if (cnt_a !== 4'd8) $display("FAIL order_bitcnt: got %0d expected 8", cnt_a); else passes++;
        tick();
        checks++; if (valid_a !== 1'b0) $display("FAIL order_valid_e1: got %b expected 0", valid_a); else passes++;
        checks++; if (busy_a !== 1'b0) $display("FAIL order_busy_idle: got %b expected 0", busy_a); else passes++;
        tick();
        checks++; if (valid_a !== 1'b1) $display("FAIL order_valid_e2: got %b expected 1", valid_a); else passes++;
        checks++; if (dout_a !== 8'hB7) $display("FAIL lsb_dout: got %h expected b7", dout_a); else passes++;
        checks++; if (dout_b !== 8'hED) $display("FAIL msb_dout: got %h expected ed", dout_b); else passes++;
        checks++; if (cnt_a !== 4'd8) $display("FAIL order_bitcnt_hold: got %0d expected 8", cnt_a); else passes++;
        checks++; if (valid_p !== 1'b0) $display("FAIL order_par_idle: got %b expected 0", valid_p); else passes++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (valid_a !== 1'b0) $display("FAIL order_ack_clear: got %b expected 0", valid_a); else passes++;
        checks++; if (dout_a !== 8'hB7) $display("FAIL order_dout_kept: got %h expected b7", dout_a); else passes++;
        $display("test_bit_order done: lsb=%h msb=%h", dout_a, dout_b);
    endtask

    task automatic test_parity();
        logic [7:0] pdata [4] = '{8'hB7, 8'h07, 8'h03, 8'hB7};
        logic       pbits [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       perrs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        par_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_frame(pdata[k], 1'b1, pbits[k], 1'b0);
            checks++; if (valid_p !== 1'b0) $display("FAIL par_valid_e0[%0d]: got %b expected 0", k, valid_p); else passes++;
            tick();
            tick();
            checks++; if (valid_p !== 1'b1) $display("FAIL par_valid_e2[%0d]: got %b expected 1", k, valid_p); else passes++;
            checks++; if (dout_p !== pdata[k]) $display("FAIL par_dout[%0d]: got %h expected %h", k, dout_p, pdata[k]); else passes++;
            checks++; if (parerr_p !== perrs[k]) $display("FAIL par_err[%0d]: got %b expected %b", k, parerr_p, perrs[k]); else passes++;
            ack = 1'b1;
            tick();
            ack = 1'b0;
            $display("parity frame %0d: data=%h pbit=%b parerr=%b", k, dout_p, pbits[k], parerr_p);
        end
        par_mode = 1'b0;
        tick();
    endtask

    task automatic test_en_gaps();
        send_frame(8'hB7, 1'b0, 1'b0, 1'b1);
        checks++; if (valid_a !== 1'b0) $display("FAIL gaps_valid_e0: got %b expected 0", valid_a); else passes++;
        tick();
        checks++; if (valid_a !== 1'b0) $display("FAIL gaps_valid_e1: got %b expected 0", valid_a); else passes++;
        tick();
        checks++; if (valid_a !== 1'b1) $display("FAIL gaps_valid_e2: got %b expected 1", valid_a); else passes++;
        checks++; if (dout_a !== 8'hB7) $display("FAIL gaps_dout: got %h expected b7", dout_a); else passes++;
        checks++; if (dout_b !== 8'hED) $display("FAIL gaps_dout_msb: got %h expected ed", dout_b); else passes++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        $display("test_en_gaps done: dout=%h", dout_a);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        tick();
        // Next start bit lands on the first IDLE cycle, the same edge frame 1 commits.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        checks++; if (valid_a !== 1'b1) $display("FAIL b2b_valid_f1: got %b expected 1", valid_a); else passes++;
        checks++; if (dout_a !== 8'h3C) $display("FAIL b2b_dout_f1: got %h expected 3c", dout_a); else passes++;
        tick();
        tick();
        checks++; if (dout_a !== 8'h3C) $display("FAIL b2b_dout_kept: got %h expected 3c", dout_a); else passes++;
        checks++; if (ovr_a !== 1'b1) $display("FAIL b2b_overrun: got %b expected 1", ovr_a); else passes++;
        checks++; if (valid_a !== 1'b1) $display("FAIL b2b_valid_held: got %b expected 1", valid_a); else passes++;
        send_frame(8'h96, 1'b0, 1'b0, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        checks++; if (dout_a !== 8'h96) $display("FAIL b2b_dout_f3: got %h expected 96", dout_a); else passes++;
        checks++; if (valid_a !== 1'b1) $display("FAIL b2b_valid_f3: got %b expected 1", valid_a); else passes++;
        checks++; if (ovr_a !== 1'b1) $display("FAIL b2b_overrun_sticky: got %b expected 1", ovr_a); else passes++;
        $display("test_back_to_back done: dout=%h overrun=%b", dout_a, ovr_a);
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] part;
        part = 4'b1101;
        ser = 1'b0;
        en  = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ser = part[i];
            tick();
        end
        checks++; if (cnt_a !== 4'd4) $display("FAIL mid_bitcnt: got %0d expected 4", cnt_a); else passes++;
        checks++; if (busy_a !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy_a); else passes++;
        rst_n = 1'b0;
        tick();
        checks++; if (dout_a !== 8'h00) $display("FAIL mid_rst_dout: got %h expected 00", dout_a); else passes++;
        checks++; if (valid_a !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", valid_a); else passes++;
        checks++; if (busy_a !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy_a); else passes++;
        checks++; if (ovr_a !== 1'b0) $display("FAIL mid_rst_overrun: got %b expected 0", ovr_a); else passes++;
        checks++; if (cnt_a !== 4'd0) $display("FAIL mid_rst_bitcnt: got %0d expected 0", cnt_a); else passes++;
        checks++; if (parerr_a !== 1'b0) $display("FAIL mid_rst_parerr: got %b expected 0", parerr_a); else passes++;
        rst_n = 1'b1;
        en    = 1'b0;
        ser   = 1'b1;
        tick();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checks++; if (dout_a !== 8'h5A) $display("FAIL mid_new_dout: got %h expected 5a", dout_a); else passes++;
        checks++; if (valid_a !== 1'b1) $display("FAIL mid_new_valid: got %b expected 1", valid_a); else passes++;
        checks++; if (ovr_a !== 1'b0) $display("FAIL mid_new_overrun: got %b expected 0", ovr_a); else passes++;
        checks++; if (cnt_a !== 4'd8) $display("FAIL mid_new_bitcnt: got %0d expected 8", cnt_a); else passes++;
        $display("test_reset_mid_frame done: dout=%h", dout_a);
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_parity();
        test_en_gaps();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
